// File: rtl/jtcps1_vram_pkg.sv
// Shared constants for the CPS1 video VRAM read arbiter: client indices,
// FSM state encoding and the default word-address width.
package jtcps1_vram_pkg;

    localparam int AW_DEF = 17;

    localparam logic [1:0] CL_PAL = 2'd0;
    localparam logic [1:0] CL_SCR = 2'd1;
    localparam logic [1:0] CL_OBJ = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Rotation order used by the arbiter: pal -> scr -> obj -> pal
    function automatic logic [1:0] next_client(input logic [1:0] c);
        return (c == CL_OBJ) ? CL_PAL : c + 2'd1;
    endfunction

endpackage

// File: rtl/jtcps1_vram_slot.sv
// Per-client result slot: remembers the last word fetched for one client and
// flags ok only while the client still asks for that exact address.
// With JTCPS1_VRAM_CACHE_EN the stored word survives cs drops until clr.
module jtcps1_vram_slot
    import jtcps1_vram_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rstn,
`ifdef JTCPS1_VRAM_CACHE_EN
    input  logic          clr,
`endif
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          capture,
    input  logic [AW-1:0] cap_addr,
    input  logic [15:0]   cap_data,
    output logic [15:0]   data,
    output logic          ok
);

    logic [AW-1:0] served_addr;
    logic          valid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            served_addr <= '0;
            data        <= '0;
            valid       <= 1'b0;
        end else begin
            if (capture) begin
                served_addr <= cap_addr;
                data        <= cap_data;
            end
`ifdef JTCPS1_VRAM_CACHE_EN
            // A clear racing a capture wins: the word may predate a CPU write
            if (clr)
                valid <= 1'b0;
            else if (capture)
                valid <= 1'b1;
`else
            if (!cs)
                valid <= 1'b0;
            else if (capture)
                valid <= 1'b1;
`endif
        end
    end

    assign ok = cs & valid & (addr == served_addr);

endmodule

// File: rtl/jtcps1_vram_arb.sv
// VRAM read arbiter: shares one SDRAM read slot between the scroll, object and
// palette fetchers. Optional JTCPS1_VRAM_CACHE_EN keeps words across cs drops.
module jtcps1_vram_arb
    import jtcps1_vram_pkg::*;
#(
    parameter int AW          = AW_DEF,
    parameter bit ROUND_ROBIN = 1'b1
) (
`ifdef JTCPS1_VRAM_CACHE_EN
    input  logic          cache_clr,
`endif
    input  logic          clk,
    input  logic          rstn,
    input  logic [AW-1:0] scr_addr,
    input  logic          scr_cs,
    output logic [15:0]   scr_data,
    output logic          scr_ok,
    input  logic [AW-1:0] obj_addr,
    input  logic          obj_cs,
    output logic [15:0]   obj_data,
    output logic          obj_ok,
    input  logic [AW-1:0] pal_addr,
    input  logic          pal_cs,
    output logic [15:0]   pal_data,
    output logic          pal_ok,
    output logic [AW-1:0] mem_addr,
    output logic          mem_cs,
    input  logic [15:0]   mem_data,
    input  logic          mem_ok,
    output logic          busy
);

    state_t        state;
    logic [1:0]    winner, rr_ptr;
    logic [1:0]    base, c1, c2, grant;
    logic          grant_vld;
    logic [2:0]    cs_v, ok_v, pending, capture;
    logic [AW-1:0] addr_v [3];

    assign cs_v[CL_PAL]   = pal_cs;
    assign cs_v[CL_SCR]   = scr_cs;
    assign cs_v[CL_OBJ]   = obj_cs;
    assign ok_v[CL_PAL]   = pal_ok;
    assign ok_v[CL_SCR]   = scr_ok;
    assign ok_v[CL_OBJ]   = obj_ok;
    assign addr_v[CL_PAL] = pal_addr;
    assign addr_v[CL_SCR] = scr_addr;
    assign addr_v[CL_OBJ] = obj_addr;
    assign pending        = cs_v & ~ok_v;
    assign busy           = (state != IDLE);

    // rr_ptr holds the client searched first; fixed mode always starts at pal
    always_comb begin
        base      = ROUND_ROBIN ? rr_ptr : CL_PAL;
        c1        = next_client(base);
        c2        = next_client(c1);
        grant_vld = |pending;
        grant     = c2;
        if (pending[c1])
            grant = c1;
        if (pending[base])
            grant = base;
    end

    always_comb begin
        for (int i = 0; i < 3; i++)
            capture[i] = (state == WAIT) && mem_ok && (winner == 2'(i));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            mem_cs   <= 1'b0;
            mem_addr <= '0;
            winner   <= CL_PAL;
            rr_ptr   <= CL_PAL;
        end else begin
            case (state)
                IDLE: if (grant_vld) begin
                    winner   <= grant;
                    mem_addr <= addr_v[grant];
                    mem_cs   <= 1'b1;
                    rr_ptr   <= next_client(grant);
                    state    <= WAIT;
                end
                WAIT: if (mem_ok) begin
                    mem_cs <= 1'b0;
                    state  <= GAP;
                end
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    jtcps1_vram_slot #(.AW(AW)) u_pal (
        .clk(clk), .rstn(rstn),
`ifdef JTCPS1_VRAM_CACHE_EN
        .clr(cache_clr),
`endif
        .cs(pal_cs), .addr(pal_addr), .capture(capture[CL_PAL]),
        .cap_addr(mem_addr), .cap_data(mem_data), .data(pal_data), .ok(pal_ok)
    );

    jtcps1_vram_slot #(.AW(AW)) u_scr (
        .clk(clk), .rstn(rstn),
`ifdef JTCPS1_VRAM_CACHE_EN
        .clr(cache_clr),
`endif
        .cs(scr_cs), .addr(scr_addr), .capture(capture[CL_SCR]),
        .cap_addr(mem_addr), .cap_data(mem_data), .data(scr_data), .ok(scr_ok)
    );

    jtcps1_vram_slot #(.AW(AW)) u_obj (
        .clk(clk), .rstn(rstn),
`ifdef JTCPS1_VRAM_CACHE_EN
        .clr(cache_clr),
`endif
        .cs(obj_cs), .addr(obj_addr), .capture(capture[CL_OBJ]),
        .cap_addr(mem_addr), .cap_data(mem_data), .data(obj_data), .ok(obj_ok)
    );

endmodule
